snn_img_sched: RTL

Image-buffer controller and job scheduler in front of `snn_core`. It takes pixel bytes from the byte receiver into a two-bank (ping-pong) 784-pixel image buffer. It launches `snn_core` whenever a full bank is waiting and the result slot is free, serves the core's 1-bit pixel reads from that bank, and holds the classified digit for the host with a valid/ack handshake. Loading of image N+1 overlaps classification of image N.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_img_buf.sv | 59 +++++
 rtl/snn_img_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared sizes and the scheduler state type for the SNN image front end.
package snn_pkg;
    localparam int NUM_PIXELS    = 784;
    localparam int BYTES_PER_IMG = NUM_PIXELS / 8;
    localparam int IMG_ADDR_W    = 10;
    localparam int WORD_W        = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DRAIN
    } sched_state_t;
endpackage

// File: rtl/snn_img_buf.sv
// Two-bank image memory: byte-wide write port, registered single-pixel read port.
module snn_img_buf #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic                           wr_bank,
    input  logic [snn_pkg::WORD_W-1:0]     wr_word,
    input  logic [7:0]                     wr_data,
    input  logic                           rd_bank,
    input  logic [snn_pkg::IMG_ADDR_W-1:0] rd_addr,
    output logic                           q
);
    localparam int DEPTH = NUM_PIXELS / 8;
    import snn_pkg::*;

    logic              in_range;
    logic [WORD_W-1:0] rd_word;
    logic [7:0]        bank_byte [2];
    logic              bank_sel_reg;
    logic              in_range_reg;
    logic [2:0]        bit_sel_reg;

    assign in_range = rd_addr < IMG_ADDR_W'(NUM_PIXELS);
    // Out-of-range addresses are steered to word 0 so the array is never over-indexed.
    assign rd_word  = in_range ? rd_addr[IMG_ADDR_W-1:3] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (we && (wr_bank == 1'(gi))) begin
                    mem[wr_word] <= wr_data;
                end
                rd_byte_reg <= mem[rd_word];
            end

            assign bank_byte[gi] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_reg <= 1'b0;
            in_range_reg <= 1'b0;
            bit_sel_reg  <= '0;
        end else begin
            bank_sel_reg <= rd_bank;
            in_range_reg <= in_range;
            bit_sel_reg  <= rd_addr[2:0];
        end
    end

    assign q = in_range_reg & bank_byte[bank_sel_reg][bit_sel_reg];
endmodule

// File: rtl/snn_img_sched.sv
// Ping-pong image loader plus job scheduler and result holder in front of snn_core.
module snn_img_sched #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    input  logic                           flush,
    output logic                           core_start,
    input  logic [snn_pkg::IMG_ADDR_W-1:0] core_addr,
    output logic                           core_q,
    input  logic                           core_done,
    input  logic [3:0]                     core_digit,
    output logic [3:0]                     result_digit,
    output logic                           result_valid,
    input  logic                           result_ack,
    output logic                           busy
);
    localparam int BYTES_PER_IMG = NUM_PIXELS / 8;
    import snn_pkg::*;

    sched_state_t      state_reg;
    logic [1:0]        full_reg;
    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic [WORD_W-1:0] byte_cnt_reg;
    logic              core_start_reg;
    logic              result_valid_reg;
    logic [3:0]        result_digit_reg;

    logic              xfer;
    logic              last_byte;
    logic              job_done;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;

    assign rx_ready  = !full_reg[wr_bank_reg] && !flush;
    assign xfer      = rx_valid && rx_ready;
    assign last_byte = byte_cnt_reg == WORD_W'(BYTES_PER_IMG - 1);
    assign job_done  = (state_reg == RUN) && core_done && !flush;
    // Completing one bank and freeing the other can coincide; both masks apply together.
    assign set_mask  = (xfer && last_byte) ? (2'b01 << wr_bank_reg) : 2'b00;
    assign clr_mask  = job_done ? (2'b01 << rd_bank_reg) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg     <= 2'b00;
            wr_bank_reg  <= 1'b0;
            byte_cnt_reg <= '0;
        end else if (flush) begin
            full_reg     <= 2'b00;
            wr_bank_reg  <= 1'b0;
            byte_cnt_reg <= '0;
        end else begin
            full_reg <= (full_reg | set_mask) & ~clr_mask;
            if (xfer) begin
                if (last_byte) begin
                    byte_cnt_reg <= '0;
                    wr_bank_reg  <= !wr_bank_reg;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            core_start_reg   <= 1'b0;
            rd_bank_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            result_digit_reg <= 4'd0;
        end else if (flush) begin
            core_start_reg   <= 1'b0;
            rd_bank_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            // A core that finishes in the flush cycle needs no draining; its digit is dropped.
            if (state_reg == START || (state_reg == RUN && !core_done)) begin
                state_reg <= DRAIN;
            end else begin
                state_reg <= IDLE;
            end
        end else begin
            core_start_reg <= 1'b0;
            if (result_ack) begin
                result_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (full_reg[rd_bank_reg] && !result_valid_reg) begin
                        state_reg      <= START;
                        core_start_reg <= 1'b1;
                    end
                end
                START: state_reg <= RUN;
                RUN: begin
                    if (core_done) begin
                        state_reg        <= IDLE;
                        result_digit_reg <= core_digit;
                        result_valid_reg <= 1'b1;
                        rd_bank_reg      <= !rd_bank_reg;
                    end
                end
                DRAIN: begin
                    if (core_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    snn_img_buf #(
        .NUM_PIXELS(NUM_PIXELS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (xfer),
        .wr_bank (wr_bank_reg),
        .wr_word (byte_cnt_reg),
        .wr_data (rx_data),
        .rd_bank (rd_bank_reg),
        .rd_addr (core_addr),
        .q       (core_q)
    );

    assign core_start   = core_start_reg;
    assign result_valid = result_valid_reg;
    assign result_digit = result_digit_reg;
    assign busy         = state_reg != IDLE;
endmodule
